// File: rtl/ldm_stm_sequencer_if.sv
// Decoder / register-file / data-memory bundle seen by the LDM/STM sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface ldm_stm_sequencer_if;
    logic        start;
    logic        is_load;
    logic        pre;
    logic        up;
    logic        wb;
    logic [3:0]  base_reg;
    logic [31:0] base_val;
    logic [15:0] reg_list;
    logic [3:0]  rf_addr_r;
    logic [31:0] rf_data_r;
    logic [3:0]  rf_addr_w;
    logic [31:0] rf_data_w;
    logic        rf_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        err;

    modport slave (
        input  start, is_load, pre, up, wb, base_reg, base_val, reg_list,
        input  rf_data_r, mem_rdata, mem_ack,
        output rf_addr_r, rf_addr_w, rf_data_w, rf_we,
        output mem_addr, mem_wdata, mem_req, mem_we,
        output busy, done, err
    );

    modport master (
        output start, is_load, pre, up, wb, base_reg, base_val, reg_list,
        output rf_data_r, mem_rdata, mem_ack,
        input  rf_addr_r, rf_addr_w, rf_data_w, rf_we,
        input  mem_addr, mem_wdata, mem_req, mem_we,
        input  busy, done, err
    );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// ARM LDM/STM block-transfer sequencer: walks the register list in ascending
// order, issues one memory transfer per set bit and optionally writes back the base.
module ldm_stm_sequencer (
    input  logic                 CP,
    input  logic                 reset,
    ldm_stm_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            r = v[i] ? 4'(i) : r;
        end
        return r;
    endfunction

    state_e      state_q;
    logic        is_load_q;
    logic        pre_q;
    logic        up_q;
    logic        wb_q;
    logic [3:0]  base_reg_q;
    logic [31:0] base_q;
    logic [15:0] list_q;
    logic        base_in_list_q;
    logic [31:0] final_q;
    logic [3:0]  cur_reg_q;
    logic [31:0] mem_addr_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [4:0]  n_s;
    logic [31:0] four_n_s;
    logic [31:0] start_addr_s;
    logic [31:0] final_s;
    logic [15:0] list_d;
    logic        rf_we_s;
    logic [3:0]  rf_addr_w_s;
    logic [31:0] rf_data_w_s;

    assign n_s      = popcount16(list_q);
    assign four_n_s = {25'd0, n_s, 2'b00};
    assign final_s  = up_q ? (base_q + four_n_s) : (base_q - four_n_s);
    assign list_d   = list_q & ~(16'd1 << cur_reg_q);

    // Start address of the block for the four addressing modes.
    always_comb begin
        start_addr_s = base_q;
        case ({up_q, pre_q})
            2'b10:   start_addr_s = base_q;
            2'b11:   start_addr_s = base_q + 32'd4;
            2'b00:   start_addr_s = base_q - four_n_s + 32'd4;
            2'b01:   start_addr_s = base_q - four_n_s;
            default: start_addr_s = base_q;
        endcase
    end

    // Register-file write port: load data in the ack cycle, base writeback in WB.
    always_comb begin
        rf_we_s     = 1'b0;
        rf_addr_w_s = 4'd0;
        rf_data_w_s = 32'd0;
        case (state_q)
            S_XFER: begin
                if (bus.mem_ack && is_load_q) begin
                    rf_we_s     = 1'b1;
                    rf_addr_w_s = cur_reg_q;
                    rf_data_w_s = bus.mem_rdata;
                end else begin
                    rf_we_s     = 1'b0;
                end
            end
            S_WB: begin
                // A loaded base register keeps the loaded value.
                rf_we_s     = !(is_load_q && base_in_list_q);
                rf_addr_w_s = base_reg_q;
                rf_data_w_s = final_q;
            end
            default: begin
                rf_we_s     = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with its registered outputs.
    always_ff @(posedge CP) begin
        if (reset) begin
            state_q        <= S_IDLE;
            is_load_q      <= 1'b0;
            pre_q          <= 1'b0;
            up_q           <= 1'b0;
            wb_q           <= 1'b0;
            base_reg_q     <= 4'd0;
            base_q         <= 32'd0;
            list_q         <= 16'd0;
            base_in_list_q <= 1'b0;
            final_q        <= 32'd0;
            cur_reg_q      <= 4'd0;
            mem_addr_q     <= 32'd0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        is_load_q      <= bus.is_load;
                        pre_q          <= bus.pre;
                        up_q           <= bus.up;
                        wb_q           <= bus.wb;
                        base_reg_q     <= bus.base_reg;
                        base_q         <= bus.base_val;
                        list_q         <= bus.reg_list;
                        base_in_list_q <= bus.reg_list[bus.base_reg];
                        busy_q         <= 1'b1;
                        state_q        <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    final_q <= final_s;
                    if (n_s == 5'd0) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cur_reg_q  <= lowest_set(list_q);
                        mem_addr_q <= start_addr_s;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= !is_load_q;
                        state_q    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (bus.mem_ack) begin
                        list_q     <= list_d;
                        mem_addr_q <= mem_addr_q + 32'd4;
                        if (list_d == 16'd0) begin
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            if (wb_q) begin
                                state_q <= S_WB;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end else begin
                            cur_reg_q <= lowest_set(list_d);
                        end
                    end
                end
                S_WB: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rf_addr_r = cur_reg_q;
    assign bus.rf_addr_w = rf_addr_w_s;
    assign bus.rf_data_w = rf_data_w_s;
    assign bus.rf_we     = rf_we_s;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = (mem_req_q && mem_we_q) ? bus.rf_data_r : 32'd0;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: expected memory transfers and register
// writes are queued at each start and consumed as the sequencer produces them.
module tb_ldm_stm_sequencer;

    typedef struct packed {
        logic        we;
        logic [3:0]  rg;
        logic [31:0] addr;
    } mem_exp_t;

    typedef struct packed {
        logic [3:0]  rg;
        logic [31:0] data;
    } rf_exp_t;

    logic CP;
    logic reset;
    ldm_stm_sequencer_if bus ();

    ldm_stm_sequencer dut (
        .CP    (CP),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ws = 0;
    logic ack_always = 1'b0;
    int wait_cnt = 0;
    int busy_total = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic err_seen = 1'b0;
    int start_cyc = 0;
    mem_exp_t mem_q[$];
    rf_exp_t  rf_q[$];

    function automatic logic [31:0] rf_val(input logic [3:0] r);
        return 32'hC0DE_0000 | {24'd0, r, r};
    endfunction

    assign bus.rf_data_r = rf_val(bus.rf_addr_r);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    always @(posedge CP) cyc++;

    // Memory model: read data equals the address, ack after ws wait cycles.
    always @(posedge CP) begin
        if (bus.mem_req && bus.mem_ack) wait_cnt = 0;
        else if (bus.mem_req) wait_cnt++;
        else wait_cnt = 0;
        #1;
        bus.mem_ack   = ack_always || (bus.mem_req && (wait_cnt >= ws));
        bus.mem_rdata = bus.mem_addr;
    end

    // Monitor: compares every transfer and register write against the queues.
    always @(negedge CP) begin
        mem_exp_t me;
        rf_exp_t  re;
        if (bus.busy) busy_total++;
        check("err_without_done", 64'(bus.err & ~bus.done), 64'd0);
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            err_seen = bus.err;
        end
        if (bus.mem_req) begin
            check("mem_pending", 64'(mem_q.size() != 0), 64'd1);
            if (mem_q.size() != 0) begin
                me = mem_q[0];
                check("mem_addr", 64'(bus.mem_addr), 64'(me.addr));
                check("mem_we", 64'(bus.mem_we), 64'(me.we));
                check("rf_addr_r", 64'(bus.rf_addr_r), 64'(me.rg));
                if (me.we) check("mem_wdata", 64'(bus.mem_wdata), 64'(rf_val(me.rg)));
                if (bus.mem_ack) void'(mem_q.pop_front());
            end
        end
        if (bus.rf_we) begin
            check("rf_pending", 64'(rf_q.size() != 0), 64'd1);
            if (rf_q.size() != 0) begin
                re = rf_q.pop_front();
                check("rf_addr_w", 64'(bus.rf_addr_w), 64'(re.rg));
                check("rf_data_w", 64'(bus.rf_data_w), 64'(re.data));
            end
        end
    end

    // Queue the expected traffic, then pulse start with the operands.
    task automatic launch(input logic ld, input logic p, input logic u, input logic w,
                          input logic [3:0] br, input logic [31:0] bv,
                          input logic [15:0] lst, input int wst,
                          output int exp_lat, output int busy0);
        int n;
        logic [31:0] a;
        logic [31:0] fin;
        logic [31:0] fourn;
        n = 0;
        for (int i = 0; i < 16; i++) if (lst[i]) n++;
        fourn = 32'(n) << 2;
        a   = u ? (p ? bv + 32'd4 : bv) : (p ? bv - fourn : bv - fourn + 32'd4);
        fin = u ? bv + fourn : bv - fourn;
        for (int i = 0; i < 16; i++) begin
            if (lst[i]) begin
                mem_q.push_back('{we: ~ld, rg: 4'(i), addr: a});
                if (ld) rf_q.push_back('{rg: 4'(i), data: a});
                a = a + 32'd4;
            end
        end
        if (n > 0 && w && !(ld && lst[br])) rf_q.push_back('{rg: br, data: fin});
        exp_lat = 2 + n + ((n > 0 && w) ? 1 : 0) + n * wst;
        ws = wst;
        @(posedge CP); #1;
        bus.start = 1'b1; bus.is_load = ld; bus.pre = p; bus.up = u; bus.wb = w;
        bus.base_reg = br; bus.base_val = bv; bus.reg_list = lst;
        start_cyc = cyc;
        busy0 = busy_total;
        @(posedge CP); #1;
        bus.start = 1'b0; bus.base_val = 32'hDEAD_BEEF; bus.reg_list = 16'hFFFF;
        bus.base_reg = 4'hF; bus.is_load = ~ld; bus.up = ~u; bus.pre = ~p;
    endtask

    task automatic finish_op(input string tag, input int exp_lat, input int busy0,
                             input logic exp_err);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge CP);
        check({tag, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_latency"}, 64'(done_cyc - start_cyc), 64'(exp_lat));
        check({tag, "_err"}, 64'(err_seen), 64'(exp_err));
        check({tag, "_busy_cycles"}, 64'(busy_total - busy0), 64'(exp_lat));
        @(negedge CP);
        check({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
        check({tag, "_mem_left"}, 64'(mem_q.size()), 64'd0);
        check({tag, "_rf_left"}, 64'(rf_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int b0;
        reset = 1'b1;
        bus.start = 1'b0; bus.is_load = 1'b0; bus.pre = 1'b0; bus.up = 1'b0; bus.wb = 1'b0;
        bus.base_reg = 4'd0; bus.base_val = 32'd0; bus.reg_list = 16'd0;
        repeat (3) @(posedge CP);
        @(negedge CP);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_rf_we", 64'(bus.rf_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_rf_addr_r", 64'(bus.rf_addr_r), 64'd0);
        check("rst_rf_addr_w", 64'(bus.rf_addr_w), 64'd0);
        check("rst_rf_data_w", 64'(bus.rf_data_w), 64'd0);
        @(posedge CP); #1;
        reset = 1'b0;

        // LDMIA r0!, {r1-r3} with ack tied high
        ack_always = 1'b1;
        launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'h100, 16'h000E, 0, lat, b0);
        check("ldmia_expected_latency", 64'(lat), 64'd6);
        finish_op("ldmia", lat, b0, 1'b0);
        ack_always = 1'b0;

        // STMDB r13!, {r4, r14}
        launch(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h200, 16'h4010, 0, lat, b0);
        finish_op("stmdb", lat, b0, 1'b0);

        // LDMIB r0!, {r0, r1}: writeback suppressed
        launch(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 32'h100, 16'h0003, 0, lat, b0);
        finish_op("ldmib_base_in_list", lat, b0, 1'b0);

        // Empty list
        launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 32'h40, 16'h0000, 0, lat, b0);
        finish_op("empty", lat, b0, 1'b1);

        // STMDA r2, {r0, r15} with three wait states per transfer
        launch(1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 32'h10, 16'h8001, 3, lat, b0);
        finish_op("stmda_wait", lat, b0, 1'b0);

        // LDMDB r3!, {r0-r2} wrapping below zero, one wait state
        launch(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h4, 16'h0007, 1, lat, b0);
        finish_op("ldmdb_wrap", lat, b0, 1'b0);

        // Reset during the second transfer of an eight-register load
        launch(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h300, 16'h00FF, 0, lat, b0);
        @(posedge CP); #1;
        @(posedge CP); #1;
        reset = 1'b1;
        @(posedge CP); #1;
        reset = 1'b0;
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        check("rstmid_mem_req", 64'(bus.mem_req), 64'd0);
        check("rstmid_rf_we", 64'(bus.rf_we), 64'd0);
        check("rstmid_mem_left", 64'(mem_q.size()), 64'd6);
        check("rstmid_rf_left", 64'(rf_q.size()), 64'd6);
        mem_q.delete();
        rf_q.delete();
        repeat (3) @(negedge CP);

        // STMIA r7!, {r7, r8} after the abandoned transfer
        launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 32'h500, 16'h0180, 0, lat, b0);
        finish_op("stmia_after_reset", lat, b0, 1'b0);

        repeat (2) @(negedge CP);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

- Drives the register file from the initiator side for ARM block transfers (LDM/STM).
- Walks a 16-bit register list in ascending order and issues one memory transfer per set bit.
  - Loads write the returned word into the register file through its write port.
  - Stores read the register through a register-file read port and pass it to memory.
- Performs optional base writeback and sits between the instruction decoder and the register file / data memory port.

## Interface
Parameters: none.

- CP  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on CP rising edge
- start  in  1  request; accepted only in IDLE
- is_load  in  1  1 = LDM, 0 = STM; latched at start
- pre  in  1  P bit; latched at start
- up  in  1  U bit; latched at start
- wb  in  1  W bit; latched at start
- base_reg  in  4  base register number; latched at start
- base_val  in  32  base register value; latched at start
- reg_list  in  16  register list; latched at start
- rf_addr_r  out  4  read-port address, i.e. the current register
- rf_data_r  in  32  combinational read data for rf_addr_r
- rf_addr_w  out  4  register-file write address
- rf_data_w  out  32  register-file write data
- rf_we  out  1  register-file write enable
- mem_addr  out  32  word address
- mem_wdata  out  32  store data, equal to rf_data_r
- mem_req  out  1  transfer request
- mem_we  out  1  1 = store
- mem_rdata  in  32  load data; valid when mem_ack=1
- mem_ack  in  1  transfer complete; ignored while mem_req=0
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done when reg_list was empty

## Operation
States: IDLE, SETUP, XFER, WB, DONE.

- **IDLE**
  - On start=1, latch all operands and go to SETUP.
  - start is ignored in every other state.
- **SETUP** (1 cycle)
  - n = popcount(list), 0..16.
  - Start address:
    - IA (up=1, pre=0): base
    - IB (up=1, pre=1): base+4
    - DA (up=0, pre=0): base−4n+4
    - DB (up=0, pre=1): base−4n
  - Final base: up ? base+4n : base−4n.
  - All arithmetic is 32-bit modulo 2^32; wrap-around is not flagged.
  - If n=0, go to DONE with err pending. No memory access and no writeback occur.
  - Otherwise go to XFER; the current register is the lowest set bit of the list.
- **XFER**
  - mem_req=1 and mem_we=!is_load.
  - mem_addr = current address; rf_addr_r = current register.
  - mem_addr, mem_we and rf_addr_r stay stable until the mem_ack cycle.
  - In the mem_ack cycle:
    - Load: rf_we=1, rf_addr_w = current register, rf_data_w = mem_rdata (combinational in that cycle).
    - Clear the current bit from the list and add 4 to the address.
  - When the list becomes empty, go to WB if wb=1, else to DONE.
- **WB** (1 cycle)
  - rf_we=1, rf_addr_w=base_reg, rf_data_w=final base.
  - Suppressed (rf_we=0) when is_load=1 and base_reg is in the original list; the loaded value wins.
  - Always go to DONE.
- **DONE** (1 cycle)
  - done=1; err=1 if n was 0.
  - Go to IDLE.
- **Register 15**
  - Treated like any other register.
  - PC-specific behaviour belongs to the register file.

## Timing
- Reset values: state IDLE; busy, done, err, mem_req, mem_we and rf_we all 0; mem_addr, mem_wdata, rf_addr_r, rf_addr_w and rf_data_w all 0.
- Reset in any state returns to IDLE at that edge and drops mem_req; an outstanding transfer is abandoned.
- Latency with zero-wait memory (mem_ack high in the first mem_req cycle):
  - start edge → SETUP 1 cycle → XFER n cycles → WB 1 cycle (if taken) → DONE 1 cycle.
  - busy is high for 2+n+wb cycles.
- Each mem_ack low cycle extends XFER by one cycle.
- The earliest next start is accepted in the cycle after DONE, when the state is IDLE.
- mem_ack while mem_req=0 has no effect.

## Test plan
- **LDMIA with writeback:** base r0=0x100, list 0x000E, wb=1, mem_ack tied high, mem_rdata = address.
  - mem_addr 0x100, 0x104, 0x108 on consecutive cycles.
  - r1=0x100, r2=0x104, r3=0x108 written.
  - WB writes r0=0x10C; done 6 cycles after start.
- **STMDB with writeback:** r13=0x200, list 0x4010, wb=1.
  - Stores r4 at 0x1F8 and r14 at 0x1FC, each with mem_wdata=rf_data_r.
  - WB writes r13=0x1F8.
- **Base in list (LDMIB):** r0=0x100, list 0x0003, wb=1.
  - Loads from 0x104 and 0x108.
  - r0 receives the loaded data; no WB write (rf_we=0 in WB).
- **Empty list:** reg_list=0, start.
  - SETUP goes directly to DONE; done=1 and err=1 in the same cycle.
  - No mem_req and no rf_we.
- **Wait states (STMDA):** mem_ack delayed 3 cycles per transfer, base 0x10, list 0x8001.
  - Addresses 0x0C then 0x10.
  - mem_addr, mem_we and rf_addr_r stable during waits.
- **Reset mid-transfer:** reset in the second XFER cycle.
  - Next cycle: IDLE, busy=0, mem_req=0, no further rf_we.
  - A new start completes normally.
